// File: rtl/addsub_accumulator.sv
// addsub_accumulator
//   Single-entry accumulator stage around a WIDTH-bit adder/subtractor.
//   An operand is accepted in IDLE, folded into the accumulator on that same
//   edge, and the result (accumulator, carry, overflow, op count) is held in
//   RESULT until the sink takes it. The stage handles at most one operation
//   every two cycles. out_zero is a live decode of the accumulator.

module addsub_accumulator #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RESULT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q,   acc_d;
  logic               cout_q,  cout_d;
  logic               ovf_q,   ovf_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  // Operand conditioned for subtraction (one's complement; the +1 comes in as carry-in).
  logic [WIDTH-1:0]   bx_s;
  // One extra bit so the carry out of the MSB is kept.
  logic [WIDTH:0]     sum_s;
  logic               ovf_s;
  logic [CNT_W-1:0]   cnt_inc_s;

  // Datapath: add/subtract of the operand into the current accumulator, plus the saturating count step.
  always_comb begin
    bx_s      = in_data ^ {WIDTH{in_sel}};
    sum_s     = {1'b0, acc_q} + {1'b0, bx_s} + {{WIDTH{1'b0}}, in_sel};
    // Signed overflow: operands share a sign but the result sign differs.
    ovf_s     = (acc_q[WIDTH-1] == bx_s[WIDTH-1]) && (sum_s[WIDTH-1] != acc_q[WIDTH-1]);
    if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_inc_s = cnt_q;
    end
  end

  // Next-state and register-update decode; state is only touched on an accepted operand.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RESULT;
          if (in_clr) begin
            acc_d  = in_data;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
            cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            acc_d  = sum_s[WIDTH-1:0];
            cout_d = sum_s[WIDTH];
            ovf_d  = ovf_s;
            cnt_d  = cnt_inc_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESULT: begin
        // A new operand is never taken here, even when the sink drains the result this cycle.
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode straight from the registers.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_RESULT);
    out_acc   = acc_q;
    out_cout  = cout_q;
    out_ovf   = ovf_q;
    out_count = cnt_q;
    out_zero  = (acc_q == {WIDTH{1'b0}});
  end

endmodule

// File: tb/tb_addsub_accumulator.sv
// tb_addsub_accumulator
//   Directed bench for addsub_accumulator. Each step compares a packed
//   observation {out_valid, in_ready, acc, cout, ovf, zero, count} against a
//   hand-computed expected vector. Inputs change on the falling edge and
//   outputs are sampled on the falling edge.

module tb_addsub_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_sel;
  logic       in_clr;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_acc;
  logic       out_cout;
  logic       out_ovf;
  logic       out_zero;
  logic [3:0] out_count;

  int n_checks;
  int n_fail;

  // {out_valid, in_ready, acc[3:0], cout, ovf, zero, count[3:0]}
  logic [12:0] obs;
  assign obs = {out_valid, in_ready, out_acc, out_cout, out_ovf, out_zero, out_count};

  addsub_accumulator #(.WIDTH(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_clr    (in_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand, wait (bounded) until it is taken, then drop in_valid.
  // Returns at the falling edge after acceptance, when the result should be visible.
  task automatic do_op(input logic clr, input logic sel, input logic [3:0] b);
    int waited;
    @(negedge clk);
    in_valid = 1'b1;
    in_clr   = clr;
    in_sel   = sel;
    in_data  = b;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL op_accept_timeout in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_clr   = 1'bx;
    in_sel   = 1'bx;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if (obs !== {1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_state got=%b required=%b", obs, {1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clear;
    do_op(1'b1, 1'b0, 4'h5);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 4'h1}) begin
      n_fail++;
      $display("FAIL clr_5 got=%b required=%b", obs, {1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 4'h1});
    end
  endtask

  task automatic test_add_sub;
    // 5 + 3 = 8: signed overflow, no carry
    do_op(1'b0, 1'b0, 4'h3);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 4'h2}) begin
      n_fail++;
      $display("FAIL add_3 got=%b required=%b", obs, {1'b1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 4'h2});
    end
    // 8 - 8 = 0: no borrow, zero
    do_op(1'b0, 1'b1, 4'h8);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h3}) begin
      n_fail++;
      $display("FAIL sub_8 got=%b required=%b", obs, {1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h3});
    end
    // 0 - 1 = F: borrow
    do_op(1'b0, 1'b1, 4'h1);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'h4}) begin
      n_fail++;
      $display("FAIL sub_1 got=%b required=%b", obs, {1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'h4});
    end
  endtask

  task automatic test_idle_hold;
    // Back in IDLE with in_valid low and in_sel/in_clr unknown: nothing changes
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== {1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h4}) begin
        n_fail++;
        $display("FAIL idle_hold[%0d] got=%b required=%b", i, obs, {1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h4});
      end
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_clr    = 1'b0;
    in_sel    = 1'b0;
    in_data   = 4'h2;
    // F + 2 = 1 with carry; operand 2 accepted at the next edge
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_data = 4'h3;  // pending operand that must wait
      n_checks++;
      if (obs !== {1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 4'h5}) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d] got=%b required=%b", i, obs, {1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 4'h5});
      end
    end
    out_ready = 1'b1;
    // Drain edge: back to IDLE, pending operand not yet taken
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 4'h5}) begin
      n_fail++;
      $display("FAIL backpressure_drain got=%b required=%b", obs, {1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 4'h5});
    end
    // Pending 1 + 3 = 4 accepted now
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (obs !== {1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 4'h6}) begin
      n_fail++;
      $display("FAIL backpressure_pending got=%b required=%b", obs, {1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 4'h6});
    end
  endtask

  task automatic test_count_saturation;
    do_op(1'b1, 1'b0, 4'h1);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 4'h1}) begin
      n_fail++;
      $display("FAIL sat_clr got=%b required=%b", obs, {1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 4'h1});
    end
    for (int i = 0; i < 20; i++) begin
      do_op(1'b0, 1'b0, 4'h1);
      if (i == 13) begin
        // 14 adds: acc 15, count reaches F
        n_checks++;
        if (obs !== {1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'hF}) begin
          n_fail++;
          $display("FAIL sat_reach got=%b required=%b", obs, {1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'hF});
        end
      end else if (i == 14) begin
        // F + 1 wraps to 0 with carry; count holds at F
        n_checks++;
        if (obs !== {1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'hF}) begin
          n_fail++;
          $display("FAIL sat_wrap got=%b required=%b", obs, {1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'hF});
        end
      end
    end
    n_checks++;
    if (obs !== {1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 4'hF}) begin
      n_fail++;
      $display("FAIL sat_final got=%b required=%b", obs, {1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 4'hF});
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    out_ready = 1'b0;
    // Clear ignores in_sel
    do_op(1'b1, 1'b1, 4'h9);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 4'h1}) begin
      n_fail++;
      $display("FAIL clr_sel_ignored got=%b required=%b", obs, {1'b1, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 4'h1});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== {1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0}) begin
      n_fail++;
      $display("FAIL async_reset got=%b required=%b", obs, {1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0});
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    // First op after reset: 0 + 6, count from 0 to 1
    do_op(1'b0, 1'b0, 4'h6);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 4'h1}) begin
      n_fail++;
      $display("FAIL post_reset_add got=%b required=%b", obs, {1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 4'h1});
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_sel    = 1'b0;
    in_clr    = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_clear();
    test_add_sub();
    test_idle_hold();
    test_backpressure();
    test_count_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
